// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, RUN/HALT fetch control.
// Optional fetch/bubble performance counters are enabled with IF_PERF_CNT_EN.
module if_stage #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [15:0] NOP_INSTR  = 16'hF000
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [15:0]           imem_data_i,
  input  logic                  imem_valid_i,
  input  logic                  pcstall_i,
  input  logic                  ifid_stall_i,
  input  logic                  ifid_flush_i,
  input  logic                  branch_taken_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  output logic [15:0]           ifid_instr_o,
  output logic [ADDR_WIDTH-1:0] ifid_pc_o,
  output logic                  ifid_valid_o,
  output logic [3:0]            opcode_o,
  output logic                  halted_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]           fetch_cnt_o,
  output logic [15:0]           bubble_cnt_o
`endif
);

  localparam logic [3:0] OP_STOP = 4'b0111;

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  fetch_ok;
  logic                  ifid_load;
  logic                  ifid_bubble;
  logic                  ifid_kill;
  logic                  pc_hold;
  logic                  stop_load;

  assign imem_addr_o = pc;
  assign opcode_o    = ifid_instr_o[15:12];

  always_comb begin
    fetch_ok    = 1'b0;
    ifid_kill   = 1'b0;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    pc_hold     = 1'b0;
    stop_load   = 1'b0;

    fetch_ok    = (state == RUN) && imem_valid_i && !pcstall_i;
    ifid_kill   = ifid_flush_i || branch_taken_i;
    // A stall without kill holds IF/ID; every other non-load cycle inserts a bubble.
    ifid_load   = !ifid_kill && !ifid_stall_i && fetch_ok;
    ifid_bubble = ifid_kill || (!ifid_stall_i && !fetch_ok);
    pc_hold     = pcstall_i || (state == HALT) || !imem_valid_i;
    stop_load   = ifid_load && (imem_data_i[15:12] == OP_STOP);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= RUN;
      halted_o     <= 1'b0;
      pc           <= '0;
      ifid_instr_o <= NOP_INSTR;
      ifid_pc_o    <= '0;
      ifid_valid_o <= 1'b0;
    end else begin
      if (branch_taken_i) begin
        pc <= branch_target_i;
      end else if (!pc_hold) begin
        pc <= pc + ADDR_WIDTH'(1);
      end

      if (ifid_load) begin
        ifid_instr_o <= imem_data_i;
        ifid_pc_o    <= pc;
        ifid_valid_o <= 1'b1;
      end else if (ifid_bubble) begin
        ifid_instr_o <= NOP_INSTR;
        ifid_pc_o    <= pc;
        ifid_valid_o <= 1'b0;
      end

      // A taken branch means any loaded STOP was on the wrong path.
      case (state)
        RUN: begin
          if (stop_load) begin
            state    <= HALT;
            halted_o <= 1'b1;
          end
        end
        HALT: begin
          if (branch_taken_i) begin
            state    <= RUN;
            halted_o <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          halted_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fetch_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (ifid_load) begin
        fetch_cnt_o <= fetch_cnt_o + 16'd1;
      end
      if (ifid_bubble) begin
        bubble_cnt_o <= bubble_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage and IF/ID pipeline register of the 16-bit pipelined processor. Holds the PC, drives the instruction-memory address, and latches each fetched 16-bit instruction with its PC into IF/ID. The decode controller takes its 4-bit opcode from IF/ID. The block obeys the hazard unit's PC-stall, IF/ID-stall and IF/ID-flush controls, redirects on a taken JMPZ, and halts fetch once a STOP enters decode.

## Interface
- ADDR_WIDTH, 8, PC / instruction-memory word-address width
- NOP_INSTR, 16'hF000, bubble instruction loaded into IF/ID (opcode 1111)
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- imem_addr_o  out  ADDR_WIDTH  instruction-memory address, equals PC register
- imem_data_i  in  16  instruction word, combinational read of imem_addr_o
- imem_valid_i  in  1  imem_data_i valid this cycle; 0 = memory wait state
- pcstall_i  in  1  hazard unit: hold PC
- ifid_stall_i  in  1  hazard unit: hold IF/ID contents
- ifid_flush_i  in  1  hazard unit: replace IF/ID with bubble
- branch_taken_i  in  1  JMPZ resolved taken
- branch_target_i  in  ADDR_WIDTH  redirect address
- ifid_instr_o  out  16  latched instruction
- ifid_pc_o  out  ADDR_WIDTH  PC of latched instruction
- ifid_valid_o  out  1  IF/ID holds a real instruction
- opcode_o  out  4  ifid_instr_o[15:12], feeds decode controller
- halted_o  out  1  fetch halted by STOP
- fetch_cnt_o, bubble_cnt_o  out  16 each  only with IF_PERF_CNT_EN

## Operation
- State machine is RUN/HALT.
  - RUN→HALT: an instruction with opcode 4'b0111 is loaded into IF/ID (a real load, not held, not bubbled).
  - HALT→RUN: branch_taken_i=1, because the STOP was on the wrong path.
  - No other exit. halted_o=1 in HALT.
- "fetch_ok" = RUN & imem_valid_i & ~pcstall_i.
- PC update, highest priority first:
  - branch_taken_i: PC←branch_target_i.
  - Else, pcstall_i, HALT or ~imem_valid_i: hold.
  - Else: PC←PC+1, wrapping modulo 2^ADDR_WIDTH.
- IF/ID update, highest priority first:
  - ifid_flush_i or branch_taken_i: bubble (instr=NOP_INSTR, valid=0, pc=PC).
  - Else, ifid_stall_i: hold all fields.
  - Else, fetch_ok: load imem_data_i, PC, valid=1.
  - Else: bubble.
- Simultaneous cases:
  - ifid_stall_i with ~pcstall_i is legal. PC advances and the word is not captured. The hazard unit never issues it, and the block does not guard against it.
  - A STOP load in the same cycle as a PC increment: PC is already PC+1. It freezes from the next cycle.
- Reset values: PC=0, imem_addr_o=0, ifid_instr_o=NOP_INSTR, ifid_pc_o=0, ifid_valid_o=0, opcode_o=4'b1111, state RUN, halted_o=0, counters 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first fetch is from address 0 on the first clock edge after deassertion.

## Timing
- imem_addr_o comes from a register. imem_data_i must settle within the same cycle.
- Fetch latency is 1 cycle: address PC in cycle n → IF/ID in cycle n+1.
- Redirect: branch_taken_i in cycle n → imem_addr_o=target in n+1 → target instruction in IF/ID in n+2. IF/ID holds a bubble in n+1.
- halted_o rises the cycle after STOP is loaded, the same cycle opcode_o=0111.
- imem_valid_i low for k cycles inserts k bubbles and holds PC for k cycles.

## Configuration
- Macro IF_PERF_CNT_EN.
- Defined:
  - fetch_cnt_o increments on every real IF/ID load.
  - bubble_cnt_o increments on every bubble load, including flush.
  - Held cycles count in neither.
  - Both wrap at 16 bits and reset to 0.
- Undefined: neither port nor either counter exists.

## Test plan
- Reset release with imem returning ADD words: PC increments 0,1,2,3. IF/ID shows pc 0,1,2 one cycle later. opcode_o=0010. valid=1.
- pcstall_i=1 and ifid_stall_i=1 for 2 cycles at PC=5: PC stays 5, IF/ID is unchanged, and fetch resumes from 5 afterwards.
- branch_taken_i with target 0x40 at PC=9:
  - next cycle imem_addr_o=0x40 and IF/ID holds a bubble (opcode 1111, valid 0);
  - the cycle after, ifid_pc_o=0x40.
- STOP (0x7000) at address 3: halted_o=1 and opcode_o=0111. PC freezes at 4 and IF/ID then holds bubbles. A later branch_taken_i to 0x10 clears halt and fetches 0x10.
- imem_valid_i low for 3 cycles at PC=2: PC holds 2 and there are 3 bubbles. With IF_PERF_CNT_EN, bubble_cnt_o rises by 3.
- ifid_flush_i and ifid_stall_i together: flush wins and IF/ID becomes a bubble. rst_n_i pulsed mid-stream returns all outputs to their reset values asynchronously.
